// File: rtl/keypad_entry.sv
// keypad_entry: consumer end of the keypad input unit.
// Synchronizes the scanner strobes, debounces/deduplicates them into one
// event per physical press, builds a BCD operand from digit keys and hands
// it to the datapath on operator keys.
module keypad_entry #(
    parameter int DIGITS         = 4,
    parameter int PRESS_CYCLES   = 50000,
    parameter int RELEASE_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            value,
    input  logic                  valid_in,
    input  logic                  valid_digit,
    input  logic                  valid_LR,
    output logic [4*DIGITS-1:0]   operand,
    output logic [3:0]            digit_count,
    output logic                  op_valid,
    output logic [3:0]            op_code,
    output logic [4*DIGITS-1:0]   op_operand,
    output logic                  key_event,
    output logic [3:0]            key_code,
    output logic                  overflow
);

    localparam int OW = 4 * DIGITS;
    localparam int AW = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [AW-1:0] AGE_LAST = AW'(PRESS_CYCLES - 1);
    localparam logic [RW-1:0] LOW_LAST = RW'(RELEASE_CYCLES - 1);
    localparam logic [3:0]    DIG_MAX  = 4'(DIGITS);
    localparam logic [3:0]    KEY_BS   = 4'd14;
    localparam logic [3:0]    KEY_CLR  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HELD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers: {valid_LR, valid_digit, valid_in, value[3:0]}
    // ------------------------------------------------------------------
    logic [6:0] sync1_d, sync1_q;
    logic [6:0] sync2_d, sync2_q;

    // Feed the raw pins into the first stage, first stage into the second.
    always_comb begin
        sync1_d = {valid_LR, valid_digit, valid_in, value};
        sync2_d = sync1_q;
    end

    // Two-flop synchronizer chain, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    logic       vin_s;
    logic       vdig_s;
    logic       vlr_s;
    logic [3:0] val_s;

    assign val_s  = sync2_q[3:0];
    assign vin_s  = sync2_q[4];
    assign vdig_s = sync2_q[5];
    assign vlr_s  = sync2_q[6];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t          state_d, state_q;
    logic [3:0]      cand_d, cand_q;
    logic [AW-1:0]   age_d, age_q;
    logic [RW-1:0]   low_d, low_q;
    logic [OW-1:0]   operand_d, operand_q;
    logic [3:0]      count_d, count_q;
    logic            op_valid_d, op_valid_q;
    logic [3:0]      op_code_d, op_code_q;
    logic [OW-1:0]   op_operand_d, op_operand_q;
    logic            key_event_d, key_event_q;
    logic [3:0]      key_code_d, key_code_q;
    logic            overflow_d, overflow_q;

    logic            accept;
    logic            released;
    logic [AW-1:0]   age_next;
    logic [RW-1:0]   low_next;

    // Saturating press-age and low-run counters; released = this cycle is
    // the RELEASE_CYCLES-th consecutive low cycle.
    always_comb begin
        age_next = (age_q == AGE_LAST) ? age_q : age_q + 1'b1;
        if (vin_s)
            low_next = '0;
        else
            low_next = (low_q == LOW_LAST) ? low_q : low_q + 1'b1;
        released = !vin_s && (low_q == LOW_LAST);
    end

    // Debounce FSM: next state, candidate capture, counters, accept strobe.
    // Acceptance also needs the key sensed in that cycle, so a short glitch
    // that ages out while the strobe is low waits and then releases.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        age_d   = age_q;
        low_d   = low_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vin_s) begin
                    cand_d  = val_s;
                    age_d   = '0;
                    low_d   = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                age_d = age_next;
                low_d = low_next;
                if (vin_s && (val_s != cand_q)) begin
                    state_d = S_IDLE;
                end else if (released) begin
                    state_d = S_IDLE;
                end else if (vin_s && (age_q == AGE_LAST)) begin
                    accept  = 1'b1;
                    state_d = S_HELD;
                end
            end
            S_HELD: begin
                low_d = low_next;
                if (released)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Acceptance actions: operand editing, operator hand-off, pulses.
    // Class priority: digit over edit over operator.
    always_comb begin
        operand_d    = operand_q;
        count_d      = count_q;
        op_code_d    = op_code_q;
        op_operand_d = op_operand_q;
        key_code_d   = key_code_q;
        op_valid_d   = 1'b0;
        key_event_d  = 1'b0;
        overflow_d   = 1'b0;
        if (accept) begin
            key_event_d = 1'b1;
            key_code_d  = cand_q;
            if (vdig_s) begin
                if (count_q < DIG_MAX) begin
                    operand_d = (operand_q << 4) | OW'(cand_q);
                    count_d   = count_q + 4'd1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (vlr_s) begin
                if (cand_q == KEY_BS) begin
                    operand_d = operand_q >> 4;
                    count_d   = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;
                end else if (cand_q == KEY_CLR) begin
                    operand_d = '0;
                    count_d   = 4'd0;
                end
            end else begin
                op_operand_d = operand_q;
                op_code_d    = cand_q;
                op_valid_d   = 1'b1;
                operand_d    = '0;
                count_d      = 4'd0;
            end
        end
    end

    // State and datapath register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cand_q       <= '0;
            age_q        <= '0;
            low_q        <= '0;
            operand_q    <= '0;
            count_q      <= '0;
            op_valid_q   <= 1'b0;
            op_code_q    <= '0;
            op_operand_q <= '0;
            key_event_q  <= 1'b0;
            key_code_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            age_q        <= age_d;
            low_q        <= low_d;
            operand_q    <= operand_d;
            count_q      <= count_d;
            op_valid_q   <= op_valid_d;
            op_code_q    <= op_code_d;
            op_operand_q <= op_operand_d;
            key_event_q  <= key_event_d;
            key_code_q   <= key_code_d;
            overflow_q   <= overflow_d;
        end
    end

    assign operand     = operand_q;
    assign digit_count = count_q;
    assign op_valid    = op_valid_q;
    assign op_code     = op_code_q;
    assign op_operand  = op_operand_q;
    assign key_event   = key_event_q;
    assign key_code    = key_code_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Consumer end of the keypad input unit. It takes the gated `value` / `valid_in` / `valid_digit` / `valid_LR` strobes from the keypad scanner and synchronizes them into the system clock domain. It debounces and deduplicates them into exactly one event per physical key press. Digit presses build a BCD operand; operator presses hand the operand to the calculator datapath with a one-cycle `op_valid` pulse.

## Interface

Parameters:
- `DIGITS`, 4, number of BCD digits in the operand (1–8).
- `PRESS_CYCLES`, 50000, clk cycles from first sighting of a key to acceptance (1 ms at 50 MHz).
- `RELEASE_CYCLES`, 200000, consecutive clk cycles with `valid_in` low that count as released. Must exceed the scanner strobe period; 4 ms.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  4  key code from the scanner.
- `valid_in`  in  1  any key present (gated by scanner sense).
- `valid_digit`  in  1  key is digit 0–9.
- `valid_LR`  in  1  key is an edit key: code 14 = backspace, 15 = clear.
- `operand`  out  4*DIGITS  current BCD entry; digit 0 is in bits [3:0].
- `digit_count`  out  4  number of digits entered, 0..DIGITS.
- `op_valid`  out  1  one-cycle pulse: an operator key was accepted.
- `op_code`  out  4  value of the accepted operator; held until the next operator.
- `op_operand`  out  4*DIGITS  `operand` captured at the operator press; held until the next operator.
- `key_event`  out  1  one-cycle pulse per accepted key of any class.
- `key_code`  out  4  code of the last accepted key.
- `overflow`  out  1  one-cycle pulse: a digit was dropped because the entry is full.

## Operation

- All inputs pass through 2-flop synchronizers. The four bits of `value` are synchronized alongside the strobes; `value` is sampled only while synced `valid_in` = 1.
- The key class is taken from the synced strobes in the acceptance cycle:
  - digit if `valid_digit`;
  - edit if `valid_LR`;
  - otherwise operator.
  - If both `valid_digit` and `valid_LR` are set, digit wins.
- FSM states:
  - IDLE: waits for synced `valid_in` = 1. On it, latch `value` into `cand`, clear the counters, and go to ARM.
  - ARM: `age` increments every cycle. `low_run` counts consecutive low cycles of `valid_in` and resets on any high.
    - Abort to IDLE, with no event, if `valid_in` is high with `value` ≠ `cand`, or if `low_run` reaches RELEASE_CYCLES.
    - When `age` reaches PRESS_CYCLES−1, accept the key and go to HELD.
  - HELD: ignore all input until `low_run` reaches RELEASE_CYCLES, then go to IDLE. A key change while still held produces no event; the key must be released first.
- Acceptance actions, all in one cycle:
  - Pulse `key_event` and set `key_code` = `cand`.
  - Digit:
    - If `digit_count` < DIGITS: `operand` ← (`operand` << 4) | `cand`, and `digit_count` +1.
    - Otherwise: `operand` is unchanged and `overflow` pulses.
  - Edit 14 (backspace): `operand` ← `operand` >> 4, and `digit_count` −1, saturating at 0.
  - Edit 15 (clear): `operand` ← 0 and `digit_count` ← 0.
  - Operator:
    - Set `op_operand` ← `operand` and `op_code` ← `cand`, and pulse `op_valid`.
    - Then clear `operand` and `digit_count`.
- A digit value > 9 with `valid_digit` set is treated as a digit anyway; no range check is performed.

## Timing

- Reset (asynchronous, `rst_n` low): state IDLE, counters 0, and every output is 0.
  - Synchronizer flops also reset to 0.
  - Reset asserted mid-ARM or mid-HELD drops the pending press; no event is generated after release.
- Latency:
  - From `valid_in` rising at the pins to entering ARM: 3 clk cycles (2 for synchronization, 1 for the FSM).
  - From entering ARM to the `key_event` / `op_valid` pulse: PRESS_CYCLES cycles.
- `operand`, `digit_count`, `op_operand`, and `op_code` update on the same edge that raises `key_event`.
- Pulses are exactly 1 cycle wide and never back-to-back; at minimum, RELEASE_CYCLES cycles separate two events.
- The counters are sized to $clog2 of their limit and saturate; they do not wrap.

## Test plan

Run with PRESS_CYCLES=4, RELEASE_CYCLES=8, DIGITS=4.

- Press 1, 2, 3 in turn, each held 20 cycles with 20-cycle gaps → three `key_event` pulses, `operand` = 16'h0123, `digit_count` = 3.
- Hold key 7 for 200 cycles with `valid_in` toggling 3 on / 3 off (scanner-like strobe) → exactly one `key_event`; `operand` ends in 4'h7.
- Enter 1, 2, 3, 4, 5 → `overflow` pulses once on 5; `operand` = 16'h1234, `digit_count` = 4.
- Enter 4, 2, then operator code 10 → `op_valid` pulse, `op_code` = 10, `op_operand` = 16'h0042; `operand` = 0 and `digit_count` = 0 on the same edge.
- Enter 9, 8, then backspace (14) → `operand` = 16'h0009, `digit_count` = 1. Then clear (15) → 0 / 0. Backspace again → stays at 0 / 0.
- Glitches and reset:
  - A 2-cycle `valid_in` glitch → no event.
  - The value changing from 5 to 6 during ARM → abort, no event.
  - `rst_n` low for 1 cycle mid-HELD → all outputs 0 and no event on release.
